dds_voice_bank: RTL and testbench
=================================

// Module: dds_voice_bank
// PURPOSE
//  Parametrised, time-multiplexed DDS phase-accumulator bank. Successor to the single-width dds stage.
//  Keeps a tuning word and a phase accumulator per voice in RAM.
//  Steps one voice per pipeline_state sweep (0->1->2) and feeds the wavetable/ADSR chain.
//  Adds over the previous stage: a handshaked config port, per-voice phase reset (note-on retrigger),
//  a wrap flag, and a RAM-clear sweep after reset.
// PARAMETERS
//  VOICES   256  number of voices (power of two)
//  VIDX_W   8    voice index width, $clog2(VOICES)
//  ACC_W    32   accumulator / tuning word width
//  PHASE_W  10   phase output width, taken from the accumulator MSBs (PHASE_W <= ACC_W)
//  BEND_W   14   pitch-bend width; used only with DDS_PITCH_BEND_EN
// PORTS
//  i_clk               in   1        system clock
//  i_reset             in   1        synchronous, active-low reset
//  i_cfg_valid         in   1        config request; held until accepted
//  o_cfg_ready         out  1        config accepted when i_cfg_valid & o_cfg_ready on a clock edge
//  i_cfg_voice_index   in   VIDX_W   target voice
//  i_cfg_tuning_code   in   ACC_W    new tuning word (per-sample phase increment)
//  i_cfg_phase_reset   in   1        also clear the voice's accumulator to 0
//  i_voice_index       in   VIDX_W   voice being processed this sweep (sampled at state 0)
//  i_pipeline_state    in   2        0 = read, 1 = add, 2 = writeback/output, 3 = idle
//  i_pitch_bend        in   BEND_W   signed global bend; present only with DDS_PITCH_BEND_EN
//  o_phase             out  PHASE_W  acc_new[ACC_W-1 -: PHASE_W]
//  o_voice_index_next  out  VIDX_W   voice index aligned with o_phase
//  o_phase_valid       out  1        1-cycle strobe in state 2
//  o_wrap              out  1        carry out of acc+tuning for this voice; valid with o_phase_valid
//  o_busy              out  1        RAM-clear sweep in progress
// BEHAVIOUR
//  Reset (i_reset == 0 at posedge):
//   - all outputs go to 0; o_busy = 1; any pending config is discarded.
//   - FSM enters CLEAR: writes tuning = 0 and acc = 0 to addresses 0..VOICES-1, one per cycle.
//   - After VOICES cycles the FSM enters RUN and o_busy drops.
//   - Reset asserted mid-sweep or mid-pipeline aborts and restarts CLEAR from address 0.
//  CLEAR: o_cfg_ready = 0; pipeline_state is ignored; o_phase_valid stays 0.
//  RUN pipeline, latency 2 clocks from state 0 to output:
//   - state 0: latch i_voice_index; read tuning[v] and acc[v].
//   - state 1: sum = {1'b0,acc} + tuning_eff (ACC_W+1 bits).
//   - state 2: acc[v] <= sum[ACC_W-1:0] (wraps modulo 2^ACC_W); o_wrap <= sum[ACC_W];
//     o_phase and o_voice_index_next update; o_phase_valid = 1.
//   - state 3, or out-of-order states: no RAM write, o_phase_valid = 0; outputs hold.
//  Config handshake:
//   - o_cfg_ready = 1 in RUN when the one-entry pending register is empty.
//   - An accepted request is committed at the next state-0 cycle (no writeback then), after which ready returns.
//   - Commit writes tuning[v]; if i_cfg_phase_reset is set it also writes acc[v] = 0.
//   - Bypass when the committing voice equals the voice read in that same state 0: the in-flight computation
//     uses the new tuning and (if phase_reset) acc = 0, so the state-2 writeback never undoes the commit.
//   - Tuning code 0 freezes the voice phase.
//  tuning_eff = tuning when the macro is absent.
// CONFIGURATION
//  DDS_PITCH_BEND_EN defined:
//   - i_pitch_bend port exists.
//   - tuning_eff = tuning + (sext(i_pitch_bend) <<< (ACC_W-BEND_W-6)), saturated to [0, 2^ACC_W-1].
//   - i_pitch_bend is sampled at state 0.
//  DDS_PITCH_BEND_EN undefined: port absent; tuning_eff = tuning; no adder or saturation logic.
// STRUCTURE
//  Shared package dds_pkg:
//   - PIPE_READ/PIPE_ADD/PIPE_WB/PIPE_IDLE state constants (shared with wavetable and ADSR).
//   - FSM encoding CLEAR/RUN.
//   - default ACC_W and PHASE_W.
//  Sub-module dds_voice_ram: simple dual-port RAM (VOICES x (2*ACC_W)), one read port, one write port,
//  synchronous read; instantiated once with tuning and acc packed per word.
// TESTING
//  1. Release reset, hold i_reset=1 -> o_busy=1 for exactly 256 clocks, o_cfg_ready=0; then o_busy=0, o_cfg_ready=1.
//  2. Cfg voice 5, tuning 20_000_000; sweep 0..255 ten times
//     -> voice 5 acc = 200_000_000, o_phase = 200_000_000>>22 = 47; other voices stay at o_phase 0.
//  3. Tuning 32'h8000_0000 on voice 3 -> o_wrap alternates 0,1,0,1 on successive voice-3 outputs; o_phase alternates 512,0.
//  4. Cfg voice 7 with phase_reset, committed while voice 7 is in flight
//     -> that writeback and o_phase for voice 7 use acc 0 plus the new tuning.
//  5. Two back-to-back cfg requests -> second waits with o_cfg_ready=0 until the next state 0; both land, none lost.
//  6. Assert reset during state 1 with a pending cfg -> pending cfg dropped, CLEAR restarts, all phases read 0 afterwards.
//     With DDS_PITCH_BEND_EN, bend = -8192 on tuning 0 -> saturates at 0; phase frozen.

Source files
------------

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared constants for the DDS voice chain. The pipeline-state
//                codes are common to the phase-accumulator bank, the
//                wavetable stage and the ADSR stage, so all three step
//                through the same read / add / writeback sweep.
//  Contents    : PIPE_* sweep codes, FSM_* bank-controller encoding,
//                DDS_ACC_W / DDS_PHASE_W default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    // Pipeline sweep codes, driven by the chain sequencer on i_pipeline_state.
    localparam logic [1:0] PIPE_READ = 2'd0;
    localparam logic [1:0] PIPE_ADD  = 2'd1;
    localparam logic [1:0] PIPE_WB   = 2'd2;
    localparam logic [1:0] PIPE_IDLE = 2'd3;

    // Bank controller: clearing the voice RAM after reset, or running.
    localparam logic [0:0] FSM_CLEAR = 1'b0;
    localparam logic [0:0] FSM_RUN   = 1'b1;

    // Default datapath widths.
    localparam int DDS_ACC_W   = 32;
    localparam int DDS_PHASE_W = 10;

endpackage : dds_pkg
`default_nettype wire

// File: rtl/dds_voice_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : dds_voice_bank_if
//  Description : Voice configuration port of the DDS voice bank. A request
//                is offered with valid and held (fields stable) until the
//                bank raises ready; it transfers on a clock edge where both
//                are high.
//  Signals     : valid        master->slave  request present
//                ready        slave->master  bank can take a request
//                voice_index  master->slave  target voice
//                tuning_code  master->slave  new per-sample phase increment
//                phase_reset  master->slave  also zero the voice accumulator
//  Modports    : master (config source), slave (voice bank)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dds_voice_bank_if
    import dds_pkg::*;
#(
    parameter int VIDX_W = 8,
    parameter int ACC_W  = DDS_ACC_W
);

    logic              valid;
    logic              ready;
    logic [VIDX_W-1:0] voice_index;
    logic [ACC_W-1:0]  tuning_code;
    logic              phase_reset;

    modport master (
        output valid,
        output voice_index,
        output tuning_code,
        output phase_reset,
        input  ready
    );

    modport slave (
        input  valid,
        input  voice_index,
        input  tuning_code,
        input  phase_reset,
        output ready
    );

endinterface : dds_voice_bank_if
`default_nettype wire

// File: rtl/dds_voice_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dds_voice_ram
//  Description : Simple dual-port voice RAM, DEPTH words of two LANE_W lanes
//                (upper lane = tuning word, lower lane = accumulator). One
//                write port with a per-lane write enable so a tuning update
//                does not need a read-modify-write of the accumulator, and
//                one synchronous read port (read-before-write on a collision).
//  Ports       : i_clk    clock
//                i_we     [1] writes the upper lane, [0] the lower lane
//                i_waddr  write address
//                i_wdata  write data, both lanes
//                i_raddr  read address, registered
//                o_rdata  read data, one clock after i_raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_voice_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LANE_W = 32
) (
    input  wire logic                  i_clk,
    input  wire logic [1:0]            i_we,
    input  wire logic [ADDR_W-1:0]     i_waddr,
    input  wire logic [2*LANE_W-1:0]   i_wdata,
    input  wire logic [ADDR_W-1:0]     i_raddr,
    output logic      [2*LANE_W-1:0]   o_rdata
);

    logic [2*LANE_W-1:0] r_mem [DEPTH];
    logic [2*LANE_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we[0]) begin
            r_mem[i_waddr][LANE_W-1:0] <= i_wdata[LANE_W-1:0];
        end
        if (i_we[1]) begin
            r_mem[i_waddr][2*LANE_W-1:LANE_W] <= i_wdata[2*LANE_W-1:LANE_W];
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : dds_voice_ram
`default_nettype wire

// File: rtl/dds_voice_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dds_voice_bank
//  Description : Time-multiplexed DDS phase-accumulator bank. Each voice keeps
//                a tuning word and an accumulator in one RAM word. One voice
//                is stepped per read/add/writeback sweep; its new phase, wrap
//                flag and index are presented after the writeback edge.
//                After reset the whole RAM is zeroed, one word per clock.
//  Ports       : i_clk               clock
//                i_reset             synchronous reset, active low
//                cfg                 config handshake (dds_voice_bank_if.slave)
//                i_voice_index       voice of this sweep, taken in PIPE_READ
//                i_pipeline_state    PIPE_READ / PIPE_ADD / PIPE_WB / PIPE_IDLE
//                i_pitch_bend        signed global bend (DDS_PITCH_BEND_EN only)
//                o_phase             top PHASE_W bits of the new accumulator
//                o_voice_index_next  voice that o_phase belongs to
//                o_phase_valid       one-clock strobe for a new o_phase
//                o_wrap              accumulator carry-out, with o_phase_valid
//                o_busy              RAM clear in progress
//  Options     : DDS_PITCH_BEND_EN - adds i_pitch_bend and a saturating bend
//                adder in front of the accumulator add.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_voice_bank
    import dds_pkg::*;
#(
    parameter int VOICES  = 256,
    parameter int VIDX_W  = $clog2(VOICES),
    parameter int ACC_W   = DDS_ACC_W,
    parameter int PHASE_W = DDS_PHASE_W
`ifdef DDS_PITCH_BEND_EN
    ,
    parameter int BEND_W  = 14
`endif
) (
    input  wire logic               i_clk,
    input  wire logic               i_reset,
    dds_voice_bank_if.slave         cfg,
    input  wire logic [VIDX_W-1:0]  i_voice_index,
    input  wire logic [1:0]         i_pipeline_state,
`ifdef DDS_PITCH_BEND_EN
    input  wire logic [BEND_W-1:0]  i_pitch_bend,
`endif
    output logic      [PHASE_W-1:0] o_phase,
    output logic      [VIDX_W-1:0]  o_voice_index_next,
    output logic                    o_phase_valid,
    output logic                    o_wrap,
    output logic                    o_busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        r_mode;
    logic [VIDX_W-1:0] r_clr_addr;

    // One-entry pending config register.
    logic              r_pend_vld;
    logic [VIDX_W-1:0] r_pend_voice;
    logic [ACC_W-1:0]  r_pend_tuning;
    logic              r_pend_reset;

    // Sweep pipeline.
    logic              r_rd_pend;      // a PIPE_READ was just issued
    logic              r_sum_vld;      // a PIPE_ADD result is waiting for PIPE_WB
    logic [VIDX_W-1:0] r_vidx;
    logic              r_byp_tune;     // commit hit the voice being read
    logic              r_byp_zero;     // ... and it cleared the accumulator
    logic [ACC_W-1:0]  r_byp_tuning;
    logic [ACC_W:0]    r_sum;
`ifdef DDS_PITCH_BEND_EN
    logic [BEND_W-1:0] r_bend;
`endif

    // Registered outputs.
    logic [PHASE_W-1:0] r_phase;
    logic [VIDX_W-1:0]  r_vnext;
    logic               r_phase_valid;
    logic               r_wrap;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                 w_run;
    logic                 w_cfg_ready;
    logic                 w_cfg_accept;
    logic                 w_commit;
    logic                 w_rd_step;
    logic                 w_add_step;
    logic                 w_wb_step;
    logic [1:0]           w_we;
    logic [VIDX_W-1:0]    w_waddr;
    logic [2*ACC_W-1:0]   w_wdata;
    logic [2*ACC_W-1:0]   w_rdata;
    logic [ACC_W-1:0]     w_tune;
    logic [ACC_W-1:0]     w_acc;
    logic [ACC_W-1:0]     w_tune_eff;
    logic [ACC_W:0]       w_sum;

    // Pipeline actions only happen in RUN and never on a reset edge, so a
    // reset landing mid-sweep cannot leave a partial commit or writeback.
    assign w_run        = (r_mode == FSM_RUN) && i_reset;
    assign w_cfg_ready  = (r_mode == FSM_RUN) && !r_pend_vld;
    assign w_cfg_accept = cfg.valid && w_cfg_ready;
    assign w_commit     = w_run && r_pend_vld && (i_pipeline_state == PIPE_READ);
    assign w_rd_step    = w_run && (i_pipeline_state == PIPE_READ);
    assign w_add_step   = w_run && (i_pipeline_state == PIPE_ADD) && r_rd_pend;
    assign w_wb_step    = w_run && (i_pipeline_state == PIPE_WB) && r_sum_vld;

    assign cfg.ready    = w_cfg_ready;

    // RAM write port: clear sweep, config commit (read slot) or accumulator
    // writeback (writeback slot). The commit and writeback never share a
    // clock because they belong to different pipeline states.
    always_comb begin
        w_we    = 2'b00;
        w_waddr = r_vidx;
        w_wdata = '0;
        if (r_mode == FSM_CLEAR) begin
            w_we    = 2'b11;
            w_waddr = r_clr_addr;
        end else if (w_commit) begin
            w_we    = {1'b1, r_pend_reset};
            w_waddr = r_pend_voice;
            w_wdata = {r_pend_tuning, {ACC_W{1'b0}}};
        end else if (w_wb_step) begin
            w_we    = 2'b01;
            w_waddr = r_vidx;
            w_wdata = {{ACC_W{1'b0}}, r_sum[ACC_W-1:0]};
        end
    end

    dds_voice_ram #(
        .DEPTH  (VOICES),
        .ADDR_W (VIDX_W),
        .LANE_W (ACC_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (i_voice_index),
        .o_rdata (w_rdata)
    );

    // The RAM returned pre-commit contents for a voice committed in the same
    // read slot, so substitute the committed values here.
    assign w_tune = r_byp_tune ? r_byp_tuning : w_rdata[2*ACC_W-1:ACC_W];
    assign w_acc  = r_byp_zero ? '0           : w_rdata[ACC_W-1:0];

`ifdef DDS_PITCH_BEND_EN
    localparam int c_BEND_SHIFT = ACC_W - BEND_W - 6;

    logic signed [ACC_W+1:0] w_bend_ext;
    logic signed [ACC_W+1:0] w_tune_bent;

    // Two guard bits: the sum can go negative or past 2^ACC_W-1.
    assign w_bend_ext  = $signed({{(ACC_W+2-BEND_W){r_bend[BEND_W-1]}}, r_bend}) <<< c_BEND_SHIFT;
    assign w_tune_bent = $signed({2'b00, w_tune}) + w_bend_ext;

    always_comb begin
        w_tune_eff = w_tune_bent[ACC_W-1:0];
        if (w_tune_bent[ACC_W+1]) begin
            w_tune_eff = '0;
        end else if (w_tune_bent[ACC_W]) begin
            w_tune_eff = '1;
        end
    end
`else
    assign w_tune_eff = w_tune;
`endif

    assign w_sum = {1'b0, w_acc} + {1'b0, w_tune_eff};

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_mode        <= FSM_CLEAR;
            r_clr_addr    <= '0;
            r_pend_vld    <= 1'b0;
            r_pend_voice  <= '0;
            r_pend_tuning <= '0;
            r_pend_reset  <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_sum_vld     <= 1'b0;
            r_vidx        <= '0;
            r_byp_tune    <= 1'b0;
            r_byp_zero    <= 1'b0;
            r_byp_tuning  <= '0;
            r_sum         <= '0;
`ifdef DDS_PITCH_BEND_EN
            r_bend        <= '0;
`endif
            r_phase       <= '0;
            r_vnext       <= '0;
            r_phase_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end else if (r_mode == FSM_CLEAR) begin
            r_clr_addr    <= r_clr_addr + 1'b1;
            r_rd_pend     <= 1'b0;
            r_sum_vld     <= 1'b0;
            r_phase_valid <= 1'b0;
            if (r_clr_addr == VIDX_W'(VOICES - 1)) begin
                r_mode <= FSM_RUN;
            end
        end else begin
            // Accept and commit are exclusive: accept needs the pending
            // register empty, commit needs it full.
            if (w_commit) begin
                r_pend_vld <= 1'b0;
            end
            if (w_cfg_accept) begin
                r_pend_vld    <= 1'b1;
                r_pend_voice  <= cfg.voice_index;
                r_pend_tuning <= cfg.tuning_code;
                r_pend_reset  <= cfg.phase_reset;
            end

            // Only an unbroken READ -> ADD -> WB sequence produces a result.
            r_rd_pend <= w_rd_step;
            r_sum_vld <= w_add_step;

            if (w_rd_step) begin
                r_vidx       <= i_voice_index;
                r_byp_tune   <= w_commit && (r_pend_voice == i_voice_index);
                r_byp_zero   <= w_commit && (r_pend_voice == i_voice_index) && r_pend_reset;
                r_byp_tuning <= r_pend_tuning;
`ifdef DDS_PITCH_BEND_EN
                r_bend       <= i_pitch_bend;
`endif
            end

            if (w_add_step) begin
                r_sum <= w_sum;
            end

            if (w_wb_step) begin
                r_phase       <= r_sum[ACC_W-1 -: PHASE_W];
                r_wrap        <= r_sum[ACC_W];
                r_vnext       <= r_vidx;
                r_phase_valid <= 1'b1;
            end else begin
                r_phase_valid <= 1'b0;
            end
        end
    end

    assign o_phase            = r_phase;
    assign o_voice_index_next = r_vnext;
    assign o_phase_valid      = r_phase_valid;
    assign o_wrap             = r_wrap;
    assign o_busy             = (r_mode == FSM_CLEAR);

endmodule : dds_voice_bank
`default_nettype wire

// File: tb/tb_dds_voice_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_voice_bank
//  Description : Directed, self-checking bench for dds_voice_bank. A vector
//                table of {config, swept voice, expected phase/wrap} records
//                covers the arithmetic; hand-written sequences cover the
//                clear sweep, back-to-back config and reset mid-pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_voice_bank;
    import dds_pkg::*;

    localparam int VOICES  = 256;
    localparam int VIDX_W  = 8;
    localparam int ACC_W   = 32;
    localparam int PHASE_W = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [VIDX_W-1:0]  voice_index;
    logic [1:0]         pipeline_state;
    logic [PHASE_W-1:0] phase;
    logic [VIDX_W-1:0]  vnext;
    logic               phase_valid;
    logic               wrap;
    logic               busy;
`ifdef DDS_PITCH_BEND_EN
    logic [13:0]        pitch_bend;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dds_voice_bank_if #(.VIDX_W(VIDX_W), .ACC_W(ACC_W)) cfg_if ();

    dds_voice_bank #(
        .VOICES  (VOICES),
        .VIDX_W  (VIDX_W),
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .cfg                (cfg_if),
        .i_voice_index      (voice_index),
        .i_pipeline_state   (pipeline_state),
`ifdef DDS_PITCH_BEND_EN
        .i_pitch_bend       (pitch_bend),
`endif
        .o_phase            (phase),
        .o_voice_index_next (vnext),
        .o_phase_valid      (phase_valid),
        .o_wrap             (wrap),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cfg_en;
        logic [7:0]  cvoice;
        logic [31:0] tuning;
        bit          preset;
        logic [7:0]  svoice;
        logic [9:0]  exp_phase;
        bit          exp_wrap;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one pipeline state for one clock; returns at the next negedge.
    task automatic do_state(input logic [1:0] s, input logic [7:0] v);
        pipeline_state = s;
        voice_index    = v;
        @(negedge clk);
    endtask

    task automatic sweep(input logic [7:0] v);
        do_state(PIPE_READ, v);
        do_state(PIPE_ADD, v);
        do_state(PIPE_WB, v);
    endtask

    // Offer a request and wait (bounded) for it to be taken.
    task automatic cfg_send(input logic [7:0] v, input logic [31:0] t, input bit pr);
        bit got = 0;
        pipeline_state       = PIPE_IDLE;
        cfg_if.valid         = 1'b1;
        cfg_if.voice_index   = v;
        cfg_if.tuning_code   = t;
        cfg_if.phase_reset   = pr;
        for (int k = 0; k < 8; k++) begin
            if (cfg_if.ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("cfg accepted within bound", got, 1);
        @(negedge clk);
        cfg_if.valid = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        int n   = 0;
        bit bad = 0;
        while (busy && n < 400) begin
            if (cfg_if.ready || phase_valid) bad = 1;
            pipeline_state = 2'(n % 3);
            voice_index    = 8'(n);
            @(negedge clk);
            n++;
        end
        pipeline_state = PIPE_IDLE;
        check({tag, " busy cycles"}, n, 256);
        check({tag, " no ready/valid while clearing"}, bad, 0);
        check({tag, " ready after clear"}, cfg_if.ready, 1);
    endtask

    initial begin
        // cfg_en cvoice tuning preset svoice phase wrap
        vecs[0]  = '{1, 8'd3,   32'h8000_0000, 0, 8'd3,   10'd512,  0};
        vecs[1]  = '{0, 8'd0,   32'h0,         0, 8'd3,   10'd0,    1};
        vecs[2]  = '{0, 8'd0,   32'h0,         0, 8'd3,   10'd512,  0};
        vecs[3]  = '{0, 8'd0,   32'h0,         0, 8'd3,   10'd0,    1};
        vecs[4]  = '{1, 8'd7,   32'h1000_0000, 0, 8'd7,   10'd64,   0};
        vecs[5]  = '{0, 8'd0,   32'h0,         0, 8'd7,   10'd128,  0};
        vecs[6]  = '{1, 8'd7,   32'h0040_0000, 1, 8'd7,   10'd1,    0};
        vecs[7]  = '{0, 8'd0,   32'h0,         0, 8'd7,   10'd2,    0};
        vecs[8]  = '{1, 8'd7,   32'h0100_0000, 1, 8'd3,   10'd512,  0};
        vecs[9]  = '{0, 8'd0,   32'h0,         0, 8'd7,   10'd4,    0};
        vecs[10] = '{1, 8'd7,   32'h0,         0, 8'd7,   10'd4,    0};
        vecs[11] = '{0, 8'd0,   32'h0,         0, 8'd7,   10'd4,    0};
        vecs[12] = '{1, 8'd9,   32'hFFFF_FFFF, 0, 8'd9,   10'd1023, 0};
        vecs[13] = '{0, 8'd0,   32'h0,         0, 8'd9,   10'd1023, 1};
        vecs[14] = '{1, 8'd255, 32'h0040_0000, 0, 8'd255, 10'd1,    0};
        vecs[15] = '{0, 8'd0,   32'h0,         0, 8'd0,   10'd0,    0};

        rst_n              = 1'b0;
        voice_index        = '0;
        pipeline_state     = PIPE_IDLE;
        cfg_if.valid       = 1'b0;
        cfg_if.voice_index = '0;
        cfg_if.tuning_code = '0;
        cfg_if.phase_reset = 1'b0;
`ifdef DDS_PITCH_BEND_EN
        pitch_bend         = '0;
`endif

        // ---- reset and clear sweep ----
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1);
        check("reset ready", cfg_if.ready, 0);
        check("reset phase", phase, 0);
        check("reset valid", phase_valid, 0);
        rst_n = 1'b1;
        wait_clear("power-up");

        // ---- voice 5 over ten full sweeps ----
        cfg_send(8'd5, 32'd20_000_000, 1'b0);
        for (int p = 0; p < 10; p++) begin
            for (int v = 0; v < VOICES; v++) begin
                sweep(8'(v));
                if (p == 0 && v == 5) check("voice5 first pass phase", phase, 4);
                if (p == 9) begin
                    check($sformatf("pass10 v%0d phase", v), phase, (v == 5) ? 47 : 0);
                    check($sformatf("pass10 v%0d vnext", v), vnext, v);
                end
            end
        end

        // ---- vector table ----
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].cfg_en) cfg_send(vecs[i].cvoice, vecs[i].tuning, vecs[i].preset);
            sweep(vecs[i].svoice);
            check($sformatf("vec%0d valid", i), phase_valid, 1);
            check($sformatf("vec%0d phase", i), phase, vecs[i].exp_phase);
            check($sformatf("vec%0d wrap", i),  wrap, vecs[i].exp_wrap);
            check($sformatf("vec%0d vnext", i), vnext, vecs[i].svoice);
        end

        // ---- strobe is one clock, outputs hold in idle ----
        do_state(PIPE_IDLE, 8'd0);
        check("strobe drops", phase_valid, 0);
        check("phase holds in idle", phase, 0);
        // out-of-order ADD/WB without a READ: no output
        do_state(PIPE_ADD, 8'd7);
        do_state(PIPE_WB, 8'd7);
        check("out-of-order no valid", phase_valid, 0);
        check("out-of-order phase holds", phase, 0);

        // ---- back-to-back config ----
        pipeline_state     = PIPE_IDLE;
        cfg_if.valid       = 1'b1;
        cfg_if.voice_index = 8'd11;
        cfg_if.tuning_code = 32'h0080_0000;
        cfg_if.phase_reset = 1'b0;
        check("b2b first ready", cfg_if.ready, 1);
        @(negedge clk);
        cfg_if.voice_index = 8'd12;
        cfg_if.tuning_code = 32'h00C0_0000;
        check("b2b second waits", cfg_if.ready, 0);
        @(negedge clk);
        check("b2b still waiting", cfg_if.ready, 0);
        do_state(PIPE_READ, 8'd20);
        check("b2b ready after commit", cfg_if.ready, 1);
        do_state(PIPE_ADD, 8'd20);
        cfg_if.valid = 1'b0;
        do_state(PIPE_WB, 8'd20);
        check("b2b v20 phase", phase, 0);
        sweep(8'd11);
        check("b2b v11 phase", phase, 2);
        sweep(8'd12);
        check("b2b v12 phase", phase, 3);

        // ---- reset during ADD with a pending config ----
        cfg_if.valid       = 1'b1;
        cfg_if.voice_index = 8'd13;
        cfg_if.tuning_code = 32'h0400_0000;
        cfg_if.phase_reset = 1'b0;
        do_state(PIPE_READ, 8'd14);
        cfg_if.valid = 1'b0;
        rst_n        = 1'b0;
        do_state(PIPE_ADD, 8'd14);
        check("midreset busy", busy, 1);
        check("midreset ready", cfg_if.ready, 0);
        check("midreset phase", phase, 0);
        check("midreset vnext", vnext, 0);
        check("midreset valid", phase_valid, 0);
        rst_n = 1'b1;
        wait_clear("post-reset");
        begin
            int nz = 0;
            for (int v = 0; v < VOICES; v++) begin
                sweep(8'(v));
                if (phase != 0 || !phase_valid) nz++;
            end
            check("post-reset voices at 0", nz, 0);
        end
        sweep(8'd13);
        check("dropped cfg v13 phase", phase, 0);

`ifdef DDS_PITCH_BEND_EN
        // ---- negative bend on a zero tuning word saturates at 0 ----
        pitch_bend = 14'h2000;
        cfg_send(8'd30, 32'h0, 1'b0);
        sweep(8'd30);
        check("bend sat phase 1", phase, 0);
        sweep(8'd30);
        check("bend sat phase 2", phase, 0);
        check("bend sat wrap", wrap, 0);
        pitch_bend = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_dds_voice_bank
`default_nettype wire
